spi_shift_register_param: RTL and testbench
===========================================

Name:
spi_shift_register_param

Overview:
- Parametrised successor to the 8-bit SPI master shift register.
- Frame width is set by a parameter; frame length can be changed at run time.
- Supports CPHA 0/1 and MSB- or LSB-first.
- Adds a tx load/ready handshake, a held rx buffer with acknowledge, overrun detection and abort on ss release.
- Sits between the SPI control FSM / baud generator (which supply SCLK edge strobes and ss) and the APB register file.

Parameters:
- DATA_WIDTH, 16, maximum frame length in bits (legal range 4..32).
- LEN_W, 5, width of frame_len; must satisfy 2**LEN_W >= DATA_WIDTH.

Ports:
- PCLK  in  1  system clock; all logic is on the rising edge.
- PRESET  in  1  synchronous active-high reset.
- ss  in  1  slave select, active low.
- cpha  in  1  clock phase; sampled at load.
- lsbfe  in  1  1 = LSB first; sampled at load.
- frame_len  in  LEN_W  frame bits minus 1; sampled at load.
- tx_data  in  DATA_WIDTH  word to transmit, right-justified.
- tx_load  in  1  load request.
- tx_ready  out  1  block is idle and accepts tx_load.
- edge_lead  in  1  one-PCLK strobe marking the SCLK leading edge.
- edge_trail  in  1  one-PCLK strobe marking the SCLK trailing edge.
- miso  in  1  serial input.
- mosi  out  1  serial output.
- rx_data  out  DATA_WIDTH  last received frame, right-justified.
- rx_valid  out  1  rx_data holds an unread frame.
- rx_ack  in  1  consumer read of rx_data.
- rx_overrun  out  1  sticky: a frame completed while rx_valid was unread.
- busy  out  1  frame loaded or in progress.
- done  out  1  one-cycle pulse when a frame completes.
- aborted  out  1  one-cycle pulse when ss rises mid-frame.

Behaviour:
- Reset (PRESET=1 at a clock edge):
  - State goes to IDLE.
  - mosi=0, rx_data=0, rx_valid=0, rx_overrun=0, busy=0, done=0, aborted=0, tx_ready=1.
  - Shift registers and bit counter are cleared.
  - Reset overrides every other input in that cycle, including mid-frame.
- Frame length:
  - N = frame_len+1.
  - frame_len >= DATA_WIDTH is clamped to DATA_WIDTH-1.
  - tx bits used are tx_data[N-1:0]; rx_data[DATA_WIDTH-1:N] reads 0.
- State IDLE:
  - tx_ready=1, busy=0.
  - When tx_load=1: latch tx_data, cpha, lsbfe and N; clear the bit counter; go to LOADED next cycle.
  - From the next cycle, mosi = first bit: tx_data[N-1] if lsbfe=0, else tx_data[0].
  - tx_load while tx_ready=0 is ignored.
- State LOADED:
  - busy=1.
  - When ss=0, go to ACTIVE. Edge strobes arriving in the same cycle are ignored.
- State ACTIVE, cpha=0:
  - edge_lead samples miso into the rx shifter.
  - edge_trail shifts the next tx bit onto mosi.
- State ACTIVE, cpha=1:
  - edge_lead shifts, except the first edge_lead of the frame, which places the first bit (mosi already holds it, so no change).
  - edge_trail samples.
- Each sample increments the bit counter.
- Bit ordering:
  - lsbfe=0: received bits enter at the LSB and shift left; the first bit ends up at bit N-1.
  - lsbfe=1: the first bit received lands at bit 0.
- Frame completion:
  - The Nth sample ends the frame.
  - In the next cycle: rx_data is updated, rx_valid=1, done=1 for one cycle, state returns to IDLE.
  - mosi holds the last bit until the next load.
- Simultaneous strobes: edge_lead and edge_trail together is illegal; edge_lead is honoured and edge_trail is dropped.
- rx_ack:
  - Clears rx_valid and rx_overrun the next cycle.
  - Completion plus rx_ack in the same cycle leaves rx_valid=1 with new data and no overrun.
  - Completion while rx_valid=1 and no rx_ack: rx_data is overwritten and rx_overrun is set.
- Abort:
  - ss=1 in ACTIVE means the frame is abandoned: go to IDLE, aborted=1 for one cycle.
  - rx_data, rx_valid and done are unchanged.
  - ss=1 in LOADED keeps the state LOADED (no abort).
- Latched cpha, lsbfe and N are fixed for the frame; input changes during the frame have no effect.

Test Plan:
- Reset mid-frame: PRESET=1 after 5 of 8 bits. Outputs return to reset values; tx_ready=1 next cycle; no done.
- DATA_WIDTH=16, frame_len=7, cpha=0, lsbfe=0, tx_data=16'h00A5, miso pattern 8'h3C:
  - mosi sequence 1,0,1,0,0,1,0,1.
  - rx_data=16'h003C, rx_valid=1, done pulse one cycle after the 8th edge_lead.
- frame_len=15, cpha=1, lsbfe=1, tx_data=16'hC001, miso pattern LSB-first 16'h8001:
  - mosi first bit 1.
  - Sampling on edge_trail.
  - rx_data=16'h8001.
- Two frames with no rx_ack: second frame gives rx_overrun=1 and holds the second frame's data. rx_ack then clears rx_valid and rx_overrun. Repeat with rx_ack on the completion cycle: rx_overrun stays 0.
- ss raised after bit 3 of 8: aborted pulse, state IDLE, rx_valid unchanged at 0. tx_load during busy is ignored (tx_data change has no effect on mosi).
- frame_len=31 with DATA_WIDTH=16: clamped to 16 bits, done after the 16th sample.

Source files
------------

// File: rtl/spi_shift_register_param_if.sv
// Bus bundle for the parametrised SPI shift register.
// The slave modport is the shift register itself; the master modport is the
// side that supplies strobes, ss, transmit words and consumes received frames.
interface spi_shift_register_param_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_W      = 5
);
  logic                  ss;
  logic                  cpha;
  logic                  lsbfe;
  logic [LEN_W-1:0]      frame_len;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_ready;
  logic                  edge_lead;
  logic                  edge_trail;
  logic                  miso;
  logic                  mosi;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ack;
  logic                  rx_overrun;
  logic                  busy;
  logic                  done;
  logic                  aborted;

  modport slave (
    input  ss, cpha, lsbfe, frame_len, tx_data, tx_load,
           edge_lead, edge_trail, miso, rx_ack,
    output tx_ready, mosi, rx_data, rx_valid, rx_overrun,
           busy, done, aborted
  );

  modport master (
    output ss, cpha, lsbfe, frame_len, tx_data, tx_load,
           edge_lead, edge_trail, miso, rx_ack,
    input  tx_ready, mosi, rx_data, rx_valid, rx_overrun,
           busy, done, aborted
  );
endinterface

// File: rtl/spi_shift_register_param.sv
// Parametrised SPI master shift register.
// Frame length is latched per frame (clamped to DATA_WIDTH), supports CPHA 0/1
// and MSB/LSB first, with tx load handshake, held rx buffer, overrun flag and
// abort when ss rises mid-frame. SCLK edges arrive as one-PCLK strobes.
module spi_shift_register_param #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_W      = 5
) (
  input logic                       PCLK,
  input logic                       PRESET,
  spi_shift_register_param_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    ACTIVE
  } state_t;

  localparam logic [LEN_W-1:0] MAX_M1 = LEN_W'(DATA_WIDTH - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [LEN_W-1:0]      len_m1;
  logic [LEN_W-1:0]      bit_cnt;
  logic                  cpha_q;
  logic                  lsbfe_q;

  logic [LEN_W-1:0]      load_len_m1;
  logic [DATA_WIDTH-1:0] load_sr;
  logic                  load_first;
  logic                  trail_eff;
  logic                  do_sample;
  logic                  do_shift;
  logic [DATA_WIDTH-1:0] tx_next;
  logic                  mosi_next;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] rx_frame;
  logic                  last_bit;

  // Load-time values, strobe decoding and next-shift values.
  // MSB-first tx words are left-aligned at load so the outgoing bit is always
  // the register MSB; LSB-first rx frames are collected from the top and
  // right-justified on completion.
  always_comb begin
    load_len_m1 = (bus.frame_len > MAX_M1) ? MAX_M1 : bus.frame_len;
    load_sr     = bus.lsbfe ? bus.tx_data : (bus.tx_data << (MAX_M1 - load_len_m1));
    load_first  = bus.lsbfe ? bus.tx_data[0] : load_sr[DATA_WIDTH-1];

    // edge_lead wins when both strobes arrive together
    trail_eff = bus.edge_trail & ~bus.edge_lead;
    do_sample = cpha_q ? trail_eff : bus.edge_lead;
    // with cpha=1 the first leading edge only presents the already-driven bit
    do_shift  = cpha_q ? (bus.edge_lead && (bit_cnt != '0)) : trail_eff;

    tx_next   = lsbfe_q ? (tx_sr >> 1) : (tx_sr << 1);
    mosi_next = lsbfe_q ? tx_next[0] : tx_next[DATA_WIDTH-1];

    rx_next   = lsbfe_q ? {bus.miso, rx_sr[DATA_WIDTH-1:1]}
                        : {rx_sr[DATA_WIDTH-2:0], bus.miso};
    rx_frame  = lsbfe_q ? (rx_next >> (MAX_M1 - len_m1)) : rx_next;
    last_bit  = (bit_cnt == len_m1);
  end

  // Frame FSM with registered outputs and rx buffer handshake.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state          <= IDLE;
      tx_sr          <= '0;
      rx_sr          <= '0;
      len_m1         <= '0;
      bit_cnt        <= '0;
      cpha_q         <= 1'b0;
      lsbfe_q        <= 1'b0;
      bus.mosi       <= 1'b0;
      bus.rx_data    <= '0;
      bus.rx_valid   <= 1'b0;
      bus.rx_overrun <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.aborted    <= 1'b0;
      bus.tx_ready   <= 1'b1;
    end else begin
      bus.done    <= 1'b0;
      bus.aborted <= 1'b0;

      if (bus.rx_ack) begin
        bus.rx_valid   <= 1'b0;
        bus.rx_overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.tx_load) begin
            tx_sr        <= load_sr;
            bus.mosi     <= load_first;
            rx_sr        <= '0;
            bit_cnt      <= '0;
            len_m1       <= load_len_m1;
            cpha_q       <= bus.cpha;
            lsbfe_q      <= bus.lsbfe;
            bus.tx_ready <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= LOADED;
          end
        end

        LOADED: begin
          if (!bus.ss) begin
            state <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (bus.ss) begin
            bus.aborted  <= 1'b1;
            bus.tx_ready <= 1'b1;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end else begin
            if (do_shift) begin
              tx_sr    <= tx_next;
              bus.mosi <= mosi_next;
            end
            if (do_sample) begin
              rx_sr <= rx_next;
              if (last_bit) begin
                bus.rx_data    <= rx_frame;
                bus.rx_valid   <= 1'b1;
                // an ack in the completion cycle consumes the old frame
                bus.rx_overrun <= !bus.rx_ack && (bus.rx_overrun || bus.rx_valid);
                bus.done       <= 1'b1;
                bus.tx_ready   <= 1'b1;
                bus.busy       <= 1'b0;
                state          <= IDLE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_register_param.sv
// Directed self-checking bench for spi_shift_register_param (DATA_WIDTH=16).
module tb_spi_shift_register_param;

  logic PCLK = 1'b0;
  logic PRESET;
  int   checks = 0;
  int   errors = 0;

  always #5 PCLK = ~PCLK;

  spi_shift_register_param_if #(.DATA_WIDTH(16), .LEN_W(5)) bus ();

  spi_shift_register_param #(.DATA_WIDTH(16), .LEN_W(5)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_load(input logic [31:0] tx, input logic [4:0] flen,
                         input logic cp, input logic lsb, input int n);
    logic first;
    bus.tx_data   = tx[15:0];
    bus.frame_len = flen;
    bus.cpha      = cp;
    bus.lsbfe     = lsb;
    bus.tx_load   = 1'b1;
    tick();
    bus.tx_load = 1'b0;
    first = lsb ? tx[0] : tx[n-1];
    checks++;
    if (bus.busy !== 1'b1 || bus.tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_handshake: busy=%b tx_ready=%b expected busy=1 tx_ready=0", bus.busy, bus.tx_ready);
    end
    checks++;
    if (bus.mosi !== first) begin
      errors++;
      $display("FAIL load_first_bit: mosi=%b expected %b", bus.mosi, first);
    end
  endtask

  // Drives nrun bits of an n-bit frame; pat holds the value the slave sends.
  task automatic run_bits(input logic [31:0] tx, input logic [31:0] pat,
                          input int n, input int nrun, input logic cp,
                          input logic lsb, input logic ack_last);
    for (int i = 0; i < nrun; i++) begin
      int k;
      k = lsb ? i : n - 1 - i;
      bus.edge_lead = 1'b1;
      if (!cp) begin
        bus.miso = pat[k];
        if (i == n - 1) bus.rx_ack = ack_last;
      end
      tick();
      bus.edge_lead = 1'b0;
      bus.rx_ack    = 1'b0;
      checks++;
      if (bus.mosi !== tx[k]) begin
        errors++;
        $display("FAIL mosi_bit%0d: mosi=%b expected %b", i, bus.mosi, tx[k]);
      end
      if (cp) begin
        bus.edge_trail = 1'b1;
        bus.miso       = pat[k];
        if (i == n - 1) bus.rx_ack = ack_last;
        tick();
        bus.edge_trail = 1'b0;
        bus.rx_ack     = 1'b0;
      end else if (i < n - 1) begin
        bus.edge_trail = 1'b1;
        tick();
        bus.edge_trail = 1'b0;
      end
      checks++;
      if (bus.done !== (i == n - 1)) begin
        errors++;
        $display("FAIL done_bit%0d: done=%b expected %b", i, bus.done, (i == n - 1));
      end
    end
  endtask

  task automatic do_frame(input logic [31:0] tx, input logic [4:0] flen,
                          input logic cp, input logic lsb, input int n,
                          input logic [31:0] pat, input logic ack_last);
    do_load(tx, flen, cp, lsb, n);
    bus.ss = 1'b0;
    tick();
    run_bits(tx, pat, n, n, cp, lsb, ack_last);
    bus.ss = 1'b1;
  endtask

  task automatic ack();
    bus.rx_ack = 1'b1;
    tick();
    bus.rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.mosi !== 1'b0 || bus.rx_data !== 16'h0000 || bus.rx_valid !== 1'b0 ||
        bus.rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: mosi=%b rx_data=%h rx_valid=%b ovr=%b expected 0/0000/0/0",
               bus.mosi, bus.rx_data, bus.rx_valid, bus.rx_overrun);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aborted !== 1'b0 || bus.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b aborted=%b tx_ready=%b expected 0/0/0/1",
               bus.busy, bus.done, bus.aborted, bus.tx_ready);
    end
  endtask

  task automatic test_basic();
    do_load(32'h00A5, 5'd7, 1'b0, 1'b0, 8);
    // stray strobe in the same cycle ss falls must be ignored
    bus.ss        = 1'b0;
    bus.edge_lead = 1'b1;
    bus.miso      = 1'b1;
    tick();
    bus.edge_lead = 1'b0;
    run_bits(32'h00A5, 32'h3C, 8, 8, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.rx_data !== 16'h003C || bus.rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_rx: rx_data=%h rx_valid=%b expected 003c/1", bus.rx_data, bus.rx_valid);
    end
    checks++;
    if (bus.tx_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: tx_ready=%b busy=%b expected 1/0", bus.tx_ready, bus.busy);
    end
    bus.edge_trail = 1'b1;
    tick();
    bus.edge_trail = 1'b0;
    bus.ss         = 1'b1;
    checks++;
    if (bus.done !== 1'b0 || bus.mosi !== 1'b1) begin
      errors++;
      $display("FAIL basic_after: done=%b mosi=%b expected 0/1", bus.done, bus.mosi);
    end
  endtask

  task automatic test_cpha1_lsb();
    ack();
    do_load(32'hC001, 5'd15, 1'b1, 1'b1, 16);
    bus.ss = 1'b0;
    tick();
    // these changes must not affect the latched frame configuration
    bus.cpha      = 1'b0;
    bus.lsbfe     = 1'b0;
    bus.frame_len = 5'd3;
    bus.tx_data   = 16'hFFFF;
    run_bits(32'hC001, 32'h8001, 16, 16, 1'b1, 1'b1, 1'b0);
    bus.ss = 1'b1;
    checks++;
    if (bus.rx_data !== 16'h8001 || bus.rx_valid !== 1'b1 || bus.rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL cpha1_rx: rx_data=%h valid=%b ovr=%b expected 8001/1/0",
               bus.rx_data, bus.rx_valid, bus.rx_overrun);
    end
  endtask

  task automatic test_overrun();
    ack();
    do_frame(32'h9, 5'd3, 1'b0, 1'b0, 4, 32'h5, 1'b0);
    checks++;
    if (bus.rx_data !== 16'h0005 || bus.rx_valid !== 1'b1 || bus.rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first: rx_data=%h valid=%b ovr=%b expected 0005/1/0",
               bus.rx_data, bus.rx_valid, bus.rx_overrun);
    end
    do_frame(32'h6, 5'd3, 1'b0, 1'b0, 4, 32'hA, 1'b0);
    checks++;
    if (bus.rx_data !== 16'h000A || bus.rx_valid !== 1'b1 || bus.rx_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_second: rx_data=%h valid=%b ovr=%b expected 000a/1/1",
               bus.rx_data, bus.rx_valid, bus.rx_overrun);
    end
    ack();
    checks++;
    if (bus.rx_valid !== 1'b0 || bus.rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_ack: valid=%b ovr=%b expected 0/0", bus.rx_valid, bus.rx_overrun);
    end
    do_frame(32'h3, 5'd3, 1'b0, 1'b0, 4, 32'h3, 1'b0);
    do_frame(32'hC, 5'd3, 1'b0, 1'b0, 4, 32'hC, 1'b1);
    checks++;
    if (bus.rx_data !== 16'h000C || bus.rx_valid !== 1'b1 || bus.rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_ack_same_cycle: rx_data=%h valid=%b ovr=%b expected 000c/1/0",
               bus.rx_data, bus.rx_valid, bus.rx_overrun);
    end
  endtask

  task automatic test_abort();
    ack();
    do_load(32'h00A5, 5'd7, 1'b0, 1'b0, 8);
    // load request while busy must be ignored; ss high while loaded holds
    bus.tx_data = 16'h0000;
    bus.tx_load = 1'b1;
    tick();
    bus.tx_load = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.aborted !== 1'b0 || bus.mosi !== 1'b1) begin
      errors++;
      $display("FAIL abort_loaded_hold: busy=%b aborted=%b mosi=%b expected 1/0/1",
               bus.busy, bus.aborted, bus.mosi);
    end
    bus.ss = 1'b0;
    tick();
    run_bits(32'h00A5, 32'h3C, 8, 3, 1'b0, 1'b0, 1'b0);
    bus.ss = 1'b1;
    tick();
    checks++;
    if (bus.aborted !== 1'b1 || bus.tx_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse: aborted=%b tx_ready=%b busy=%b expected 1/1/0",
               bus.aborted, bus.tx_ready, bus.busy);
    end
    checks++;
    if (bus.rx_valid !== 1'b0 || bus.done !== 1'b0 || bus.rx_data !== 16'h000C) begin
      errors++;
      $display("FAIL abort_rx_hold: valid=%b done=%b rx_data=%h expected 0/0/000c",
               bus.rx_valid, bus.done, bus.rx_data);
    end
    tick();
    checks++;
    if (bus.aborted !== 1'b0) begin
      errors++;
      $display("FAIL abort_one_cycle: aborted=%b expected 0", bus.aborted);
    end
  endtask

  task automatic test_clamp();
    do_frame(32'hF00F, 5'd31, 1'b0, 1'b0, 16, 32'h1234, 1'b0);
    checks++;
    if (bus.rx_data !== 16'h1234 || bus.rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL clamp_rx: rx_data=%h valid=%b expected 1234/1", bus.rx_data, bus.rx_valid);
    end
  endtask

  task automatic test_reset_midframe();
    do_load(32'h00A5, 5'd7, 1'b0, 1'b0, 8);
    bus.ss = 1'b0;
    tick();
    run_bits(32'h00A5, 32'h3C, 8, 5, 1'b0, 1'b0, 1'b0);
    PRESET        = 1'b1;
    bus.edge_lead = 1'b1;
    tick();
    bus.edge_lead = 1'b0;
    checks++;
    if (bus.mosi !== 1'b0 || bus.rx_data !== 16'h0000 || bus.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_data: mosi=%b rx_data=%h valid=%b expected 0/0000/0",
               bus.mosi, bus.rx_data, bus.rx_valid);
    end
    checks++;
    if (bus.tx_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: tx_ready=%b busy=%b done=%b expected 1/0/0",
               bus.tx_ready, bus.busy, bus.done);
    end
    PRESET = 1'b0;
    for (int j = 0; j < 3; j++) begin
      bus.edge_lead = 1'b1;
      tick();
      bus.edge_lead = 1'b0;
      tick();
    end
    bus.ss = 1'b1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_after: done=%b busy=%b tx_ready=%b expected 0/0/1",
               bus.done, bus.busy, bus.tx_ready);
    end
  endtask

  initial begin
    PRESET         = 1'b1;
    bus.ss         = 1'b1;
    bus.cpha       = 1'b0;
    bus.lsbfe      = 1'b0;
    bus.frame_len  = '0;
    bus.tx_data    = '0;
    bus.tx_load    = 1'b0;
    bus.edge_lead  = 1'b0;
    bus.edge_trail = 1'b0;
    bus.miso       = 1'b0;
    bus.rx_ack     = 1'b0;
    tick();
    tick();
    PRESET = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_cpha1_lsb();
    test_overrun();
    test_abort();
    test_clamp();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
